hamming_classifier: RTL and testbench

HAMMING_CLASSIFIER -- requirements
Module: hamming_classifier

---
 rtl/hdc_pkg.sv | 30 +++
 rtl/chunk_popcount.sv | 28 ++
 rtl/hamming_classifier.sv | 145 ++++++++++++++
 tb/tb_hamming_classifier.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// ============================================================================
// hdc_pkg : shared defaults, FSM state encoding and width helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package hdc_pkg;

  localparam int DEFAULT_DIMENSIONS  = 10000;
  localparam int DEFAULT_PAR_BITS    = 10;
  localparam int DEFAULT_NUM_CLASSES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CMP  = 2'd2
  } state_e;

  // Width needed to hold a Hamming distance in the range 0..dims.
  function automatic int dist_width(input int dims);
    return $clog2(dims + 1);
  endfunction

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_popcount.sv
// ============================================================================
// chunk_popcount : combinational XOR of two PAR_BITS slices plus popcount
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module chunk_popcount #(
  parameter int PAR_BITS = 10,
  parameter int CNT_W    = $clog2(PAR_BITS + 1)
) (
  input  logic [PAR_BITS-1:0] a_bits,
  input  logic [PAR_BITS-1:0] b_bits,
  output logic [CNT_W-1:0]    count
);

  logic [PAR_BITS-1:0] diff;

  always_comb begin
    diff  = a_bits ^ b_bits;
    count = '0;
    for (int i = 0; i < PAR_BITS; i++) begin
      count = count + CNT_W'(diff[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hamming_classifier.sv
// ============================================================================
// hamming_classifier : nearest-prototype search by chunked Hamming distance
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module hamming_classifier
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS  = DEFAULT_DIMENSIONS,
  parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
  parameter int PAR_BITS    = DEFAULT_PAR_BITS
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  en,
  input  logic [DIMENSIONS-1:0]                                 query_hv,
  input  logic [NUM_CLASSES-1:0][DIMENSIONS-1:0]                class_hvs,
  output logic                                                  out,
  output logic [index_width(NUM_CLASSES)-1:0]                   class_out,
  output logic [NUM_CLASSES-1:0][dist_width(DIMENSIONS)-1:0]    dist_out
);

  localparam int DIST_W = dist_width(DIMENSIONS);
  localparam int IDX_W  = index_width(NUM_CLASSES);
  localparam int D_W    = index_width(DIMENSIONS);
  localparam int CNT_W  = $clog2(PAR_BITS + 1);

  localparam logic [D_W-1:0]   LAST_D   = D_W'(DIMENSIONS - PAR_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  if ((DIMENSIONS % PAR_BITS) != 0 || NUM_CLASSES < 2) begin : g_bad_params
    $error("hamming_classifier: DIMENSIONS must be a multiple of PAR_BITS and NUM_CLASSES must be >= 2");
  end

  state_e                                  state_q, state_d;
  logic [D_W-1:0]                          d_q, d_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic [NUM_CLASSES-1:0][DIST_W-1:0]      acc_q, acc_d;
  logic [DIST_W-1:0]                       min_q, min_d;
  logic [IDX_W-1:0]                        min_idx_q, min_idx_d;
  logic                                    out_q, out_d;
  logic [IDX_W-1:0]                        class_out_q, class_out_d;
  logic [NUM_CLASSES-1:0][DIST_W-1:0]      dist_out_q, dist_out_d;

  logic [NUM_CLASSES-1:0][CNT_W-1:0]       chunk_cnt;
  logic [DIST_W-1:0]                       acc_sel;
  logic                                    take_new;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    chunk_popcount #(
      .PAR_BITS (PAR_BITS),
      .CNT_W    (CNT_W)
    ) u_chunk_popcount (
      .a_bits (query_hv[d_q +: PAR_BITS]),
      .b_bits (class_hvs[c][d_q +: PAR_BITS]),
      .count  (chunk_cnt[c])
    );
  end

  // Index 0 seeds the running minimum; later entries replace it only when strictly smaller.
  assign acc_sel  = acc_q[idx_q];
  assign take_new = (idx_q == '0) || (acc_sel < min_q);

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    min_d       = min_q;
    min_idx_d   = min_idx_q;
    out_d       = out_q;
    class_out_d = class_out_q;
    dist_out_d  = dist_out_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          d_d     = '0;
          idx_d   = '0;
          acc_d   = '0;
          out_d   = 1'b0;
          state_d = ACC;
        end
      end
      ACC: begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          acc_d[c] = acc_q[c] + DIST_W'(chunk_cnt[c]);
        end
        if (d_q == LAST_D) begin
          idx_d   = '0;
          state_d = CMP;
        end else begin
          d_d = d_q + D_W'(PAR_BITS);
        end
      end
      CMP: begin
        if (take_new) begin
          min_d     = acc_sel;
          min_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          class_out_d = take_new ? idx_q : min_idx_q;
          dist_out_d  = acc_q;
          out_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      d_q         <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      min_q       <= '0;
      min_idx_q   <= '0;
      out_q       <= 1'b1;
      class_out_q <= '0;
      dist_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      min_q       <= min_d;
      min_idx_q   <= min_idx_d;
      out_q       <= out_d;
      class_out_q <= class_out_d;
      dist_out_q  <= dist_out_d;
    end
  end

  assign out       = out_q;
  assign class_out = class_out_q;
  assign dist_out  = dist_out_q;

endmodule

`default_nettype wire

// File: tb/tb_hamming_classifier.sv
// ============================================================================
// tb_hamming_classifier : directed + random checks against a bit-level model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hamming_classifier;

  localparam int DA    = 10000;
  localparam int PA    = 10;
  localparam int NA    = 2;
  localparam int DWA   = $clog2(DA + 1);
  localparam int DB    = 20;
  localparam int PB    = 10;
  localparam int NB    = 3;
  localparam int DWB   = $clog2(DB + 1);
  localparam int LAT_A = DA / PA + NA;
  localparam int LAT_B = DB / PB + NB;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst_a, en_a, out_a;
  logic [DA-1:0]                q_a;
  logic [NA-1:0][DA-1:0]        c_a;
  logic [0:0]                   cls_a;
  logic [NA-1:0][DWA-1:0]       dist_a;

  logic                         rst_b, en_b, out_b;
  logic [DB-1:0]                q_b;
  logic [NB-1:0][DB-1:0]        c_b;
  logic [1:0]                   cls_b;
  logic [NB-1:0][DWB-1:0]       dist_b;

  hamming_classifier u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .en        (en_a),
    .query_hv  (q_a),
    .class_hvs (c_a),
    .out       (out_a),
    .class_out (cls_a),
    .dist_out  (dist_a)
  );

  hamming_classifier #(
    .DIMENSIONS  (DB),
    .NUM_CLASSES (NB),
    .PAR_BITS    (PB)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .en        (en_b),
    .query_hv  (q_b),
    .class_hvs (c_b),
    .out       (out_b),
    .class_out (cls_b),
    .dist_out  (dist_b)
  );

  int errors = 0;
  int checks = 0;

  logic [0:0]             ref_cls_a, prev_cls_a;
  logic [NA-1:0][DWA-1:0] ref_dist_a, prev_dist_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count differing bits directly, then pick the first smallest distance.
  task automatic model_a();
    int d[NA];
    int best;
    best = 0;
    for (int c = 0; c < NA; c++) begin
      d[c] = 0;
      for (int i = 0; i < DA; i++) if (q_a[i] !== c_a[c][i]) d[c]++;
    end
    for (int c = 1; c < NA; c++) if (d[c] < d[best]) best = c;
    for (int c = 0; c < NA; c++) ref_dist_a[c] = DWA'(d[c]);
    ref_cls_a = 1'(best);
  endtask

  function automatic logic [DA-1:0] rand_vec_a();
    logic [DA-1:0] v;
    for (int i = 0; i < DA; i++) v[i] = 1'($urandom_range(1));
    return v;
  endfunction

  function automatic logic [DA-1:0] flip_mask(input int n, input bit ends);
    logic [DA-1:0] m;
    int cnt;
    int k;
    m   = '0;
    cnt = 0;
    if (ends) begin
      m[0]    = 1'b1;
      m[DA-1] = 1'b1;
      cnt     = 2;
    end
    while (cnt < n) begin
      k = int'($urandom_range(DA - 1));
      if (!m[k]) begin
        m[k] = 1'b1;
        cnt++;
      end
    end
    return m;
  endfunction

  task automatic start_a();
    model_a();
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    check("busy_a", 64'(out_a), 64'd0);
  endtask

  // en_mode: 0 = en low, 1 = en held high, 2 = en toggled randomly while busy
  task automatic finish_a(input string tag, input int en_mode);
    int lat;
    bit held;
    lat  = 0;
    held = 1'b1;
    while (out_a !== 1'b1 && lat < LIMIT) begin
      if (en_mode == 1)                    en_a = 1'b1;
      else if (en_mode == 2 && lat < 900)  en_a = 1'($urandom_range(1));
      else                                 en_a = 1'b0;
      @(negedge clk);
      lat++;
      if (out_a !== 1'b1 && (cls_a !== prev_cls_a || dist_a !== prev_dist_a)) held = 1'b0;
    end
    en_a = (en_mode == 1);
    check({tag, "_lat"},  64'(lat),    64'(LAT_A));
    check({tag, "_hold"}, 64'(held),   64'd1);
    check({tag, "_cls"},  64'(cls_a),  64'(ref_cls_a));
    check({tag, "_dist"}, 64'(dist_a), 64'(ref_dist_a));
    prev_cls_a  = ref_cls_a;
    prev_dist_a = ref_dist_a;
  endtask

  task automatic run_b(input string tag);
    int d[NB];
    int best;
    int lat;
    logic [1:0]             exp_cls;
    logic [NB-1:0][DWB-1:0] exp_dist;
    best = 0;
    for (int c = 0; c < NB; c++) begin
      d[c] = 0;
      for (int i = 0; i < DB; i++) if (q_b[i] !== c_b[c][i]) d[c]++;
    end
    for (int c = 1; c < NB; c++) if (d[c] < d[best]) best = c;
    for (int c = 0; c < NB; c++) exp_dist[c] = DWB'(d[c]);
    exp_cls = 2'(best);
    en_b = 1'b1;
    @(negedge clk);
    en_b = 1'b0;
    check({tag, "_busy"}, 64'(out_b), 64'd0);
    lat = 0;
    while (out_b !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"},  64'(lat),    64'(LAT_B));
    check({tag, "_cls"},  64'(cls_b),  64'(exp_cls));
    check({tag, "_dist"}, 64'(dist_b), 64'(exp_dist));
  endtask

  initial begin
    logic [DA-1:0] m;
    rst_a = 1'b1; en_a = 1'b1; q_a = '0; c_a = '0;
    rst_b = 1'b1; en_b = 1'b0; q_b = '0; c_b = '0;
    prev_cls_a = '0; prev_dist_a = '0;
    repeat (3) @(negedge clk);

    // Reset state (en held high during reset must not start anything)
    check("rst_out_a",  64'(out_a),  64'd1);
    check("rst_cls_a",  64'(cls_a),  64'd0);
    check("rst_dist_a", 64'(dist_a), 64'd0);
    check("rst_out_b",  64'(out_b),  64'd1);
    check("rst_cls_b",  64'(cls_b),  64'd0);
    check("rst_dist_b", 64'(dist_b), 64'd0);

    // Identical vs complemented prototype, started on the first edge after reset release
    q_a    = rand_vec_a();
    c_a[0] = q_a;
    c_a[1] = ~q_a;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    start_a();
    finish_a("ident", 0);
    check("ident_d1_is_dims", 64'(dist_a[1]), 64'(DA));

    // Tie: both prototypes identical, 500 bits away
    q_a    = rand_vec_a();
    c_a[0] = q_a ^ flip_mask(500, 1'b0);
    c_a[1] = c_a[0];
    start_a();
    finish_a("tie", 0);

    // Class 1 closer, with differences at both end bits
    q_a    = rand_vec_a();
    c_a[0] = q_a ^ flip_mask(500, 1'b0);
    c_a[1] = q_a ^ flip_mask(37, 1'b1);
    start_a();
    finish_a("ends", 0);

    // Reset mid-operation, asserted together with en
    q_a    = rand_vec_a();
    c_a[0] = q_a ^ flip_mask(1200, 1'b0);
    c_a[1] = q_a ^ flip_mask(800, 1'b0);
    start_a();
    repeat (499) @(negedge clk);
    rst_a = 1'b1;
    en_a  = 1'b1;
    @(negedge clk);
    check("midrst_out",  64'(out_a),  64'd1);
    check("midrst_cls",  64'(cls_a),  64'd0);
    check("midrst_dist", 64'(dist_a), 64'd0);
    prev_cls_a  = '0;
    prev_dist_a = '0;
    rst_a = 1'b0;
    start_a();
    finish_a("after_rst", 0);

    // Back-to-back with en held high, then random en pulses while busy
    q_a    = rand_vec_a();
    c_a[0] = q_a ^ flip_mask(3000, 1'b0);
    c_a[1] = q_a ^ flip_mask(2999, 1'b0);
    model_a();
    en_a = 1'b1;
    @(negedge clk);
    check("b2b_busy", 64'(out_a), 64'd0);
    finish_a("b2b1", 1);
    q_a    = rand_vec_a();
    c_a[0] = q_a ^ flip_mask(40, 1'b1);
    c_a[1] = q_a ^ flip_mask(41, 1'b0);
    model_a();
    @(negedge clk);
    check("b2b_one_cycle", 64'(out_a), 64'd0);
    finish_a("b2b2", 2);
    @(negedge clk);
    check("b2b_no_restart", 64'(out_a), 64'd1);

    // Random prototypes on the default configuration
    for (int t = 0; t < 3; t++) begin
      q_a    = rand_vec_a();
      m      = flip_mask(int'($urandom_range(4000)), 1'b0);
      c_a[0] = q_a ^ m;
      c_a[1] = (t == 2) ? c_a[0] : (q_a ^ flip_mask(int'($urandom_range(4000)), 1'b0));
      start_a();
      finish_a("rand_a", 0);
    end

    // Small configuration: distances 20, 3, 3
    q_b    = 20'($urandom);
    c_b[0] = ~q_b;
    c_b[1] = q_b ^ 20'h00013;
    c_b[2] = q_b ^ 20'h80402;
    run_b("small");
    check("small_cls_is_1", 64'(cls_b), 64'd1);

    for (int t = 0; t < 20; t++) begin
      q_b = 20'($urandom);
      for (int c = 0; c < NB; c++) c_b[c] = q_b ^ (20'($urandom) & 20'($urandom));
      if (t % 4 == 0) c_b[2] = c_b[1];
      run_b("rand_b");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
